// File: rtl/uart_axil_pkg.sv
// Shared constants and state types for the UART command to AXI4-Lite bridge.
package uart_axil_pkg;

  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] ST_AXI_TO = 8'h04;

  typedef enum logic [2:0] {
    StIdle,
    StRxAddr,
    StRxData,
    StAxiAwW,
    StAxiB,
    StAxiAr,
    StAxiR,
    StTxResp
  } state_e;

  typedef enum logic [1:0] {
    SerIdle,
    SerSend,
    SerWaitBusy,
    SerWaitIdle
  } ser_state_e;

endpackage

// File: rtl/uart_resp_ser.sv
// Response serializer: shifts out 1 or 5 bytes MSB first, pacing each byte on the
// transmitter busy flag (wait for busy to rise, then fall, before the next byte).
module uart_resp_ser
  import uart_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        len5,
  input  logic [39:0] data,
  input  logic        tx_busy,
  output logic        tx_vld,
  output logic [7:0]  tx_dat,
  output logic        done
);

  ser_state_e  state_q, state_d;
  logic [39:0] sh_q, sh_d;
  logic [2:0]  rem_q, rem_d;
  logic        vld_q, vld_d;
  logic [7:0]  dat_q, dat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SerIdle;
      sh_q    <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    done    = 1'b0;
    unique case (state_q)
      SerIdle: begin
        if (load) begin
          sh_d    = data;
          rem_d   = len5 ? 3'd5 : 3'd1;
          state_d = SerSend;
        end
      end
      SerSend: begin
        if (!tx_busy) begin
          vld_d   = 1'b1;
          dat_d   = sh_q[39:32];
          sh_d    = {sh_q[31:0], 8'h00};
          rem_d   = rem_q - 3'd1;
          state_d = SerWaitBusy;
        end
      end
      SerWaitBusy: begin
        if (tx_busy) state_d = SerWaitIdle;
      end
      SerWaitIdle: begin
        if (!tx_busy) begin
          if (rem_q == 3'd0) begin
            done    = 1'b1;
            state_d = SerIdle;
          end else begin
            state_d = SerSend;
          end
        end
      end
      default: state_d = SerIdle;
    endcase
  end

  assign tx_vld = vld_q;
  assign tx_dat = dat_q;

endmodule

// File: rtl/uart_axil_bridge.sv
// UART byte-frame command responder: parses write/read frames, issues one AXI4-Lite
// transaction per frame and returns status (and read data) bytes to the UART.
module uart_axil_bridge
  import uart_axil_pkg::*;
#(
  parameter int unsigned P_TIMEOUT_CYC = 1_000_000,
  parameter int unsigned P_AXI_TO_CYC  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx_vld,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_stpbt_err,
  output logic        o_tx_vld,
  output logic [7:0]  o_tx_dat,
  input  logic        i_tx_busy,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  status_q, status_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] ibt_q, ibt_d;
  logic [31:0] axi_cnt_q, axi_cnt_d;
  logic        ibt_to, axi_to, go_tx, ser_load, ser_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      is_wr_q   <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      status_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ibt_q     <= '0;
      axi_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      status_q  <= status_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ibt_q     <= ibt_d;
      axi_cnt_q <= axi_cnt_d;
    end
  end

  assign ibt_to = (P_TIMEOUT_CYC != 32'd0) && (ibt_q >= P_TIMEOUT_CYC);
  assign axi_to = (axi_cnt_q + 32'd1 >= P_AXI_TO_CYC);

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ibt_d     = ibt_q;
    axi_cnt_d = axi_cnt_q;
    go_tx     = 1'b0;
    ser_load  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_rx_vld && !i_rx_stpbt_err && (i_rx_dat == CMD_WR || i_rx_dat == CMD_RD)) begin
          is_wr_d = (i_rx_dat == CMD_WR);
          cnt_d   = 2'd0;
          ibt_d   = '0;
          state_d = StRxAddr;
        end
      end
      StRxAddr, StRxData: begin
        if (i_rx_vld) begin
          ibt_d = '0;
          if (i_rx_stpbt_err) begin
            state_d = StIdle;
          end else begin
            if (state_q == StRxAddr) addr_d = {addr_q[23:0], i_rx_dat};
            else                     wdata_d = {wdata_q[23:0], i_rx_dat};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              axi_cnt_d = '0;
              aw_done_d = 1'b0;
              w_done_d  = 1'b0;
              if (state_q == StRxData) state_d = StAxiAwW;
              else if (is_wr_q)        state_d = StRxData;
              else                     state_d = StAxiAr;
            end
          end
        end else if (ibt_to) begin
          state_d = StIdle;
        end else begin
          ibt_d = ibt_q + 32'd1;
        end
      end
      StAxiAwW: begin
        // AW and W complete independently; advance once both have been accepted
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) begin
          axi_cnt_d = '0;
          state_d   = StAxiB;
        end else if (axi_to) begin
          status_d = ST_AXI_TO;
          rdata_d  = '0;
          go_tx    = 1'b1;
        end else begin
          axi_cnt_d = axi_cnt_q + 32'd1;
        end
      end
      StAxiB: begin
        if (m_axi_bvalid) begin
          status_d = {6'b0, m_axi_bresp};
          rdata_d  = '0;
          go_tx    = 1'b1;
        end else if (axi_to) begin
          status_d = ST_AXI_TO;
          rdata_d  = '0;
          go_tx    = 1'b1;
        end else begin
          axi_cnt_d = axi_cnt_q + 32'd1;
        end
      end
      StAxiAr: begin
        if (m_axi_arready) begin
          axi_cnt_d = '0;
          state_d   = StAxiR;
        end else if (axi_to) begin
          status_d = ST_AXI_TO;
          rdata_d  = '0;
          go_tx    = 1'b1;
        end else begin
          axi_cnt_d = axi_cnt_q + 32'd1;
        end
      end
      StAxiR: begin
        if (m_axi_rvalid) begin
          status_d = {6'b0, m_axi_rresp};
          rdata_d  = m_axi_rdata;
          go_tx    = 1'b1;
        end else if (axi_to) begin
          status_d = ST_AXI_TO;
          rdata_d  = '0;
          go_tx    = 1'b1;
        end else begin
          axi_cnt_d = axi_cnt_q + 32'd1;
        end
      end
      StTxResp: begin
        if (ser_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (go_tx) begin
      ser_load = 1'b1;
      state_d  = StTxResp;
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_awvalid = (state_q == StAxiAwW) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == StAxiAwW) && !w_done_q;
  assign m_axi_wstrb   = (state_q == StAxiAwW) ? 4'hF : 4'h0;
  assign m_axi_bready  = (state_q == StAxiB);
  assign m_axi_arvalid = (state_q == StAxiAr);
  assign m_axi_rready  = (state_q == StAxiR);

  uart_resp_ser u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .len5    (!is_wr_q),
    .data    ({status_d, rdata_d}),
    .tx_busy (i_tx_busy),
    .tx_vld  (o_tx_vld),
    .tx_dat  (o_tx_dat),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed bench for uart_axil_bridge with a simple AXI4-Lite slave and UART TX model.
module tb_uart_axil_bridge;

  localparam int unsigned TO_CYC  = 100;
  localparam int unsigned AXI_TO  = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx_vld, i_rx_stpbt_err, i_tx_busy;
  logic [7:0]  i_rx_dat;
  logic        o_tx_vld;
  logic [7:0]  o_tx_dat;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  // Slave configuration and observation
  logic        sl_aw_en = 1'b1;
  logic [31:0] sl_rdata = '0;
  logic [1:0]  sl_rresp = '0, sl_bresp = '0;
  logic        aw_got, w_got;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [31:0] aw_seen = '0, w_seen = '0, ar_seen = '0;
  logic [3:0]  wstrb_seen = '0;
  int          cyc = 0, last_hs_cyc = 0, first_tx_cyc = 0, tx_viol = 0, busy_timer = 0;
  logic [7:0]  tx_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_axil_bridge #(
    .P_TIMEOUT_CYC (TO_CYC),
    .P_AXI_TO_CYC  (AXI_TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_vld       (i_rx_vld),
    .i_rx_dat       (i_rx_dat),
    .i_rx_stpbt_err (i_rx_stpbt_err),
    .o_tx_vld       (o_tx_vld),
    .o_tx_dat       (o_tx_dat),
    .i_tx_busy      (i_tx_busy),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready)
  );

  assign m_axi_awready = sl_aw_en;
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;
  assign i_tx_busy     = (busy_timer != 0) && (busy_timer <= 4);

  // Slave response channels
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= 1'b0; w_got <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= '0;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= '0; m_axi_rdata <= '0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
      if (m_axi_wvalid && m_axi_wready) w_got <= 1'b1;
      if (aw_got && w_got && !m_axi_bvalid) begin
        m_axi_bvalid <= 1'b1; m_axi_bresp <= sl_bresp;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1; m_axi_rdata <= sl_rdata; m_axi_rresp <= sl_rresp;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // Observation counters and UART TX model (busy rises 2 cycles after a pulse, lasts 4)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_axi_awvalid && m_axi_awready) begin aw_cnt <= aw_cnt + 1; aw_seen <= m_axi_awaddr; end
    if (m_axi_wvalid && m_axi_wready) begin
      w_cnt <= w_cnt + 1; w_seen <= m_axi_wdata; wstrb_seen <= m_axi_wstrb;
    end
    if (m_axi_arvalid && m_axi_arready) begin ar_cnt <= ar_cnt + 1; ar_seen <= m_axi_araddr; end
    if ((m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready)) last_hs_cyc <= cyc;
    if (o_tx_vld) begin
      if (busy_timer != 0) tx_viol <= tx_viol + 1;
      if (tx_q.size() == 0) first_tx_cyc <= cyc;
      tx_q.push_back(o_tx_dat);
      busy_timer <= 6;
    end else if (busy_timer != 0) begin
      busy_timer <= busy_timer - 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge clk);
    i_rx_vld = 1'b1; i_rx_dat = b; i_rx_stpbt_err = err;
    @(negedge clk);
    i_rx_vld = 1'b0; i_rx_stpbt_err = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b0);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b0);
  endtask

  task automatic wait_tx(input int n, input string name);
    int i;
    i = 0;
    while (tx_q.size() < n && i < 1000) begin @(negedge clk); i++; end
    repeat (20) @(negedge clk);
    checks++;
    if (tx_q.size() !== n) begin
      $display("FAIL %s_tx_count: got %0d bytes, expected %0d", name, tx_q.size(), n);
      errors++;
    end
  endtask

  function automatic logic [39:0] tx_word5();
    logic [39:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w = {w[31:0], (i < tx_q.size()) ? tx_q[i] : 8'hxx};
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; i_rx_vld = 1'b0; i_rx_dat = '0; i_rx_stpbt_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, o_tx_vld}
        !== 6'b0) begin
      $display("FAIL reset_valids: got %b expected 000000", {m_axi_awvalid, m_axi_wvalid,
               m_axi_bready, m_axi_arvalid, m_axi_rready, o_tx_vld});
      errors++;
    end
    checks++;
    if ({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, o_tx_dat} !== 76'h0) begin
      $display("FAIL reset_data: got %h expected 0",
               {m_axi_awaddr, m_axi_wdata, m_axi_wstrb, o_tx_dat});
      errors++;
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int aw0;
    aw0 = aw_cnt; tx_q.delete(); sl_bresp = 2'd0;
    send_write(32'h0000_1000, 32'hDEAD_BEEF);
    wait_tx(1, "wr");
    checks++;
    if (aw_cnt - aw0 !== 1 || aw_seen !== 32'h0000_1000) begin
      $display("FAIL wr_aw: got %0d x %h expected 1 x 00001000", aw_cnt - aw0, aw_seen);
      errors++;
    end
    checks++;
    if (w_seen !== 32'hDEAD_BEEF || wstrb_seen !== 4'hF) begin
      $display("FAIL wr_w: got %h/%h expected deadbeef/f", w_seen, wstrb_seen);
      errors++;
    end
    checks++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h00) begin
      $display("FAIL wr_status: got %h expected 00", (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      errors++;
    end
    checks++;
    if (first_tx_cyc - last_hs_cyc > 2) begin
      $display("FAIL wr_latency: got %0d cycles expected <= 2", first_tx_cyc - last_hs_cyc);
      errors++;
    end
  endtask

  task automatic test_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                           input logic [39:0] exp, input string name);
    int ar0;
    ar0 = ar_cnt; tx_q.delete(); sl_rdata = d; sl_rresp = r;
    send_read(a);
    wait_tx(5, name);
    checks++;
    if (ar_cnt - ar0 !== 1 || ar_seen !== a) begin
      $display("FAIL %s_ar: got %0d x %h expected 1 x %h", name, ar_cnt - ar0, ar_seen, a);
      errors++;
    end
    checks++;
    if (tx_word5() !== exp) begin
      $display("FAIL %s_bytes: got %h expected %h", name, tx_word5(), exp);
      errors++;
    end
    checks++;
    if (first_tx_cyc - last_hs_cyc > 2) begin
      $display("FAIL %s_latency: got %0d cycles expected <= 2", name,
               first_tx_cyc - last_hs_cyc);
      errors++;
    end
  endtask

  task automatic test_stop_err();
    int aw0, w0;
    aw0 = aw_cnt; w0 = w_cnt;
    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    test_read(32'h0000_2008, 32'hA5A5_5A5A, 2'd0, 40'h00_A5A5_5A5A, "stperr_rd");
    checks++;
    if (aw_cnt - aw0 !== 0 || w_cnt - w0 !== 0) begin
      $display("FAIL stperr_no_write: got aw %0d w %0d expected 0 0", aw_cnt - aw0, w_cnt - w0);
      errors++;
    end
  endtask

  task automatic test_ibt_timeout();
    int ar0;
    ar0 = ar_cnt; tx_q.delete();
    send_byte(8'h52, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (TO_CYC + 30) @(negedge clk);
    send_byte(8'h41, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (ar_cnt - ar0 !== 0 || tx_q.size() !== 0) begin
      $display("FAIL ibt_silent: got ar %0d tx %0d expected 0 0", ar_cnt - ar0, tx_q.size());
      errors++;
    end
    test_read(32'h0000_3000, 32'h0BAD_F00D, 2'd0, 40'h00_0BAD_F00D, "ibt_rd");
  endtask

  task automatic test_axi_timeout();
    int aw0;
    aw0 = aw_cnt; tx_q.delete(); sl_aw_en = 1'b0;
    send_write(32'h0000_4000, 32'h1111_2222);
    wait_tx(1, "axito");
    checks++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h04) begin
      $display("FAIL axito_status: got %h expected 04", (tx_q.size() > 0) ? tx_q[0] : 8'hxx);
      errors++;
    end
    checks++;
    if (aw_cnt - aw0 !== 0 || m_axi_awvalid !== 1'b0 || m_axi_bready !== 1'b0) begin
      $display("FAIL axito_idle: got aw %0d awvalid %b bready %b expected 0 0 0",
               aw_cnt - aw0, m_axi_awvalid, m_axi_bready);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    tx_q.delete(); sl_aw_en = 1'b1;
    send_byte(8'h57, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0);
    checks++;
    if (m_axi_awaddr !== 32'h0000_1000) begin
      $display("FAIL rstmid_addr_before: got %h expected 00001000", m_axi_awaddr);
      errors++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, o_tx_vld}
        !== 6'b0 || {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb, o_tx_dat} !== 108'h0)
    begin
      $display("FAIL rstmid_outputs: got addr %h wdata %h txdat %h expected all 0",
               m_axi_awaddr, m_axi_wdata, o_tx_dat);
      errors++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    tx_q.delete(); sl_bresp = 2'd1;
    send_write(32'h0000_2000, 32'h0102_0304);
    wait_tx(1, "b2b_wr");
    checks++;
    if (tx_q.size() < 1 || tx_q[0] !== 8'h01 || w_seen !== 32'h0102_0304) begin
      $display("FAIL b2b_wr_status: got %h/%h expected 01/01020304",
               (tx_q.size() > 0) ? tx_q[0] : 8'hxx, w_seen);
      errors++;
    end
    test_read(32'h0000_2000, 32'h55AA_55AA, 2'd0, 40'h00_55AA_55AA, "b2b_rd");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(32'h0000_1004, 32'h1234_5678, 2'd0, 40'h00_1234_5678, "rd");
    test_read(32'h0000_1008, 32'hCAFE_F00D, 2'd2, 40'h02_CAFE_F00D, "rd_slverr");
    test_stop_err();
    test_ibt_timeout();
    test_axi_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (tx_viol !== 0) begin
      $display("FAIL tx_handshake: got %0d pulses while busy expected 0", tx_viol);
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
